// File: rtl/packet_pkg.sv
// Shared packet layout, default sizing and shaper FSM encoding for the switch ingress path.
// Also provides the header sanity check used when SHAPER_HDR_CHECK_EN is defined.
package packet_pkg;

    localparam int PACKET_WIDTH = 16;
    localparam int DEPTH        = 8;
    localparam int SRC_LSB      = 0;
    localparam int TGT_LSB      = 4;
    localparam int TYPE_LSB     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } shaper_state_e;

    // A packet is unroutable from this port if it has no target, targets its own
    // ingress port, or claims a source other than this port.
    function automatic logic hdr_bad(input logic [7:0] hdr, input logic [1:0] port_id);
        logic [3:0] src;
        logic [3:0] tgt;
        src = hdr[SRC_LSB +: 4];
        tgt = hdr[TGT_LSB +: 4];
        return (tgt == 4'b0000) || tgt[port_id] || (src != (4'b0001 << port_id));
    endfunction

endpackage

// File: rtl/shaper_buf.sv
// Small circular FIFO with extra-MSB pointers; the head entry is visible combinationally
// so the shaper can inspect it before popping.
module shaper_buf #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: resetting the pointers discards the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/port_credit_shaper.sv
// Credit-based ingress shaper in front of one switch_4port input FIFO, with optional pacing.
// Define SHAPER_HDR_CHECK_EN to drop packets whose header cannot be routed from PORT_ID.
module port_credit_shaper #(
    parameter int  PACKET_WIDTH = packet_pkg::PACKET_WIDTH,
    parameter int  DEPTH        = packet_pkg::DEPTH,
    parameter int  BUF_DEPTH    = 4,
    parameter int  PORT_ID      = 0,
    parameter int  MIN_GAP      = 0,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    up_valid,
    output logic                    up_ready,
    input  logic [PACKET_WIDTH-1:0] up_data,
    output logic                    sw_valid_in,
    output logic [PACKET_WIDTH-1:0] sw_data_in,
    output logic [3:0]              sw_source_in,
    output logic [3:0]              sw_target_in,
    input  logic                    credit_return,
    output logic [CW-1:0]           credits,
    output logic [15:0]             tx_count,
    output logic [15:0]             bad_count,
    output logic                    cred_err
);
    import packet_pkg::*;

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
`ifdef SHAPER_HDR_CHECK_EN
    localparam bit HDR_CHECK = 1'b1;
`else
    localparam bit HDR_CHECK = 1'b0;
`endif

    shaper_state_e             state_q, state_d;
    logic [PACKET_WIDTH-1:0]   data_q, data_d;
    logic [CW-1:0]             credits_q, credits_d;
    logic [15:0]               tx_q, tx_d;
    logic [15:0]               bad_q, bad_d;
    logic                      err_q, err_d;
    logic [GW-1:0]             gap_q, gap_d;

    logic                      buf_push, buf_pop, buf_full, buf_empty;
    logic [PACKET_WIDTH-1:0]   head;
    logic [AW:0]               buf_count_unused;
    logic                      head_bad, launch, discard, sending;

    assign buf_push = up_valid && !buf_full;
    assign head_bad = HDR_CHECK && hdr_bad(head[7:0], 2'(PORT_ID));
    assign sending  = (state_q == ST_SEND);

    shaper_buf #(
        .WIDTH (PACKET_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (buf_pop),
        .wdata (up_data),
        .rdata (head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_count_unused)
    );

    // A simultaneous send and return cancel; a return at full credit is a protocol error.
    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        if (credit_return && credits_q == CRED_MAX) err_d = 1'b1;
        if (sending && !credit_return)
            credits_d = credits_q - 1'b1;
        else if (credit_return && !sending && credits_q != CRED_MAX)
            credits_d = credits_q + 1'b1;
        tx_d   = sending ? tx_q + 16'd1 : tx_q;
        bad_d  = (discard && bad_q != 16'hFFFF) ? bad_q + 16'd1 : bad_q;
        data_d = launch ? head : data_q;
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        buf_pop = 1'b0;
        launch  = 1'b0;
        discard = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!buf_empty && head_bad) begin
                    buf_pop = 1'b1;
                    discard = 1'b1;
                end else if (!buf_empty && credits_q != '0) begin
                    buf_pop = 1'b1;
                    launch  = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (MIN_GAP > 0) begin
                    gap_d   = '0;
                    state_d = ST_GAP;
                end else if (!buf_empty && !head_bad && credits_d != '0) begin
                    buf_pop = 1'b1;
                    launch  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                // The final gap cycle doubles as the launch decision so the period is MIN_GAP+1.
                if (gap_q != GAP_LAST) begin
                    gap_d = gap_q + 1'b1;
                end else if (!buf_empty && !head_bad && credits_q != '0) begin
                    buf_pop = 1'b1;
                    launch  = 1'b1;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            credits_q <= CRED_MAX;
            tx_q      <= '0;
            bad_q     <= '0;
            err_q     <= 1'b0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            credits_q <= credits_d;
            tx_q      <= tx_d;
            bad_q     <= bad_d;
            err_q     <= err_d;
            gap_q     <= gap_d;
        end
    end

    always_comb begin
        up_ready     = !buf_full;
        sw_valid_in  = sending;
        sw_data_in   = data_q;
        sw_source_in = data_q[SRC_LSB +: 4];
        sw_target_in = data_q[TGT_LSB +: 4];
        credits      = credits_q;
        tx_count     = tx_q;
        bad_count    = bad_q;
        cred_err     = err_q;
    end

endmodule
